// File: rtl/toeplitz_acc.sv
// rtl/toeplitz_acc.sv - Toeplitz hash accumulator consuming a column stream and raw input words
//
// Purpose: pairs column k of the Toeplitz matrix with bit k of an N-bit input
// block and XOR-accumulates the selected columns into an L-bit hash; one hash
// is emitted per N-bit block.
//
// Ports:
//   clk         clock, all logic on posedge
//   reset       synchronous reset, active low
//   col         L-bit matrix column, qualified by col_valid / col_ready
//   data_in     BS-bit raw input word (bit 0 consumed first), data_valid / data_ready
//   hash        completed L-bit hash, held stable while hash_valid
//   hash_valid  hash available; cleared by hash_ready
//   hash_par    (TOEPLITZ_PARITY_EN only) XOR reduction of hash, registered with it
//
// Optional feature macro: TOEPLITZ_PARITY_EN

module toeplitz_acc #(
   parameter int BS = 64,
   parameter int N  = 256,
   parameter int L  = 128
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [L-1:0]  col,
   input  logic          col_valid,
   output logic          col_ready,
   input  logic [BS-1:0] data_in,
   input  logic          data_valid,
   output logic          data_ready,
   output logic [L-1:0]  hash,
   output logic          hash_valid,
   input  logic          hash_ready
`ifdef TOEPLITZ_PARITY_EN
   ,
   output logic          hash_par
`endif
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = $clog2(BS + 1);

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t        state_q;
   logic [L-1:0]  acc_q;
   logic [L-1:0]  acc_d;
   logic [BS-1:0] buf_q;
   logic [BW-1:0] bits_left_q;
   logic [CW-1:0] cnt_q;
   logic [L-1:0]  hash_q;
   logic          hash_valid_q;
`ifdef TOEPLITZ_PARITY_EN
   logic          hash_par_q;
`endif

   // Data and column fires are mutually exclusive because they key off the
   // empty/non-empty state of the bit buffer.
   assign data_ready = (state_q == ST_ACC) && (bits_left_q == '0);
   assign col_ready  = (state_q == ST_ACC) && (bits_left_q != '0);

   // Accumulator value including the column presented this cycle.
   always_comb begin
      acc_d = acc_q ^ (buf_q[0] ? col : '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_ACC;
         acc_q        <= '0;
         buf_q        <= '0;
         bits_left_q  <= '0;
         cnt_q        <= '0;
         hash_q       <= '0;
         hash_valid_q <= 1'b0;
`ifdef TOEPLITZ_PARITY_EN
         hash_par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_ACC: begin
               if (data_ready && data_valid) begin
                  buf_q       <= data_in;
                  bits_left_q <= BW'(BS);
               end else if (col_ready && col_valid) begin
                  buf_q       <= buf_q >> 1;
                  bits_left_q <= bits_left_q - BW'(1);
                  if (cnt_q == CW'(N - 1)) begin
                     // Last column of the block: publish and restart.
                     hash_q       <= acc_d;
                     hash_valid_q <= 1'b1;
                     acc_q        <= '0;
                     cnt_q        <= '0;
                     state_q      <= ST_OUT;
`ifdef TOEPLITZ_PARITY_EN
                     hash_par_q   <= ^acc_d;
`endif
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            ST_OUT: begin
               if (hash_ready) begin
                  hash_valid_q <= 1'b0;
                  state_q      <= ST_ACC;
               end
            end
            default: state_q <= ST_ACC;
         endcase
      end
   end

   assign hash       = hash_q;
   assign hash_valid = hash_valid_q;
`ifdef TOEPLITZ_PARITY_EN
   assign hash_par   = hash_par_q;
`endif

endmodule

// File: tb/tb_toeplitz_acc.sv
// tb/tb_toeplitz_acc.sv - directed and random checks for toeplitz_acc (small and default instances)

module tb_toeplitz_acc;

   logic clk;
   logic rst_n;

   // Small instance: N=8, BS=4, L=4
   logic [3:0]  s_col;
   logic        s_col_valid, s_col_ready;
   logic [3:0]  s_data_in;
   logic        s_data_valid, s_data_ready;
   logic [3:0]  s_hash;
   logic        s_hash_valid, s_hash_ready;

   // Default instance: N=256, BS=64, L=128
   logic [127:0] d_col;
   logic         d_col_valid, d_col_ready;
   logic [63:0]  d_data_in;
   logic         d_data_valid, d_data_ready;
   logic [127:0] d_hash;
   logic         d_hash_valid, d_hash_ready;

`ifdef TOEPLITZ_PARITY_EN
   logic s_par, d_par;
`endif

   int checks = 0;
   int errors = 0;

   toeplitz_acc #(.BS(4), .N(8), .L(4)) dut_s (
      .clk(clk), .reset(rst_n),
      .col(s_col), .col_valid(s_col_valid), .col_ready(s_col_ready),
      .data_in(s_data_in), .data_valid(s_data_valid), .data_ready(s_data_ready),
      .hash(s_hash), .hash_valid(s_hash_valid), .hash_ready(s_hash_ready)
`ifdef TOEPLITZ_PARITY_EN
      , .hash_par(s_par)
`endif
   );

   toeplitz_acc dut_d (
      .clk(clk), .reset(rst_n),
      .col(d_col), .col_valid(d_col_valid), .col_ready(d_col_ready),
      .data_in(d_data_in), .data_valid(d_data_valid), .data_ready(d_data_ready),
      .hash(d_hash), .hash_valid(d_hash_valid), .hash_ready(d_hash_ready)
`ifdef TOEPLITZ_PARITY_EN
      , .hash_par(d_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the small instance until nfire columns have been accepted.
   // Words come from bits[3:0], bits[7:4]; column k is colv[4k+3:4k].
   task automatic feed_small(input logic [7:0] bits, input logic [31:0] colv, input int nfire);
      int  wi, ci, guard;
      bit  df, cf;
      wi = 0; ci = 0; guard = 0;
      while (ci < nfire && guard < 100) begin
         @(negedge clk);
         s_data_valid = (wi < 2);
         s_data_in    = bits[(wi % 2)*4 +: 4];
         s_col_valid  = 1'b1;
         s_col        = colv[(ci % 8)*4 +: 4];
         df = s_data_ready && s_data_valid;
         cf = s_col_ready && s_col_valid;
         @(posedge clk);
         if (df) wi++;
         if (cf) ci++;
         guard++;
      end
      #1;
      s_data_valid = 1'b0;
      s_col_valid  = 1'b0;
      if (ci < nfire) begin
         checks++; errors++;
         $display("FAIL feed_timeout got %0d columns need %0d", ci, nfire);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b0) begin errors++; $display("FAIL rst_s_hash_valid got %b exp 0", s_hash_valid); end
      checks++; if (s_hash !== 4'h0) begin errors++; $display("FAIL rst_s_hash got %h exp 0", s_hash); end
      checks++; if (s_col_ready !== 1'b0) begin errors++; $display("FAIL rst_s_col_ready got %b exp 0", s_col_ready); end
      checks++; if (s_data_ready !== 1'b1) begin errors++; $display("FAIL rst_s_data_ready got %b exp 1", s_data_ready); end
      checks++; if (d_hash_valid !== 1'b0) begin errors++; $display("FAIL rst_d_hash_valid got %b exp 0", d_hash_valid); end
      checks++; if (d_hash !== 128'h0) begin errors++; $display("FAIL rst_d_hash got %h exp 0", d_hash); end
      checks++; if (d_col_ready !== 1'b0) begin errors++; $display("FAIL rst_d_col_ready got %b exp 0", d_col_ready); end
      checks++; if (d_data_ready !== 1'b1) begin errors++; $display("FAIL rst_d_data_ready got %b exp 1", d_data_ready); end
`ifdef TOEPLITZ_PARITY_EN
      checks++; if (s_par !== 1'b0) begin errors++; $display("FAIL rst_s_par got %b exp 0", s_par); end
`endif
   endtask

   // Sources always valid from reset release: first hash after 4*(64+1) = 260 cycles.
   task automatic test_timing;
      int cyc, lows;
      d_data_in    = 64'h3;
      d_col        = 128'h5;
      d_data_valid = 1'b1;
      d_col_valid  = 1'b1;
      d_hash_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0; lows = 0;
      while (cyc < 400) begin
         if (!d_col_ready) lows++;
         @(posedge clk);
         cyc++;
         #1;
         if (d_hash_valid) break;
         @(negedge clk);
      end
      @(negedge clk);
      d_data_valid = 1'b0;
      d_col_valid  = 1'b0;
      checks++; if (cyc != 260) begin errors++; $display("FAIL timing_first_valid got %0d exp 260", cyc); end
      checks++; if (lows != 4) begin errors++; $display("FAIL timing_col_ready_low got %0d exp 4", lows); end
      @(negedge clk);
      checks++; if (d_hash_valid !== 1'b0) begin errors++; $display("FAIL timing_valid_one_cycle got %b exp 0", d_hash_valid); end
      checks++; if (d_data_ready !== 1'b1) begin errors++; $display("FAIL timing_resume_ready got %b exp 1", d_data_ready); end
   endtask

   task automatic test_basic;
      s_hash_ready = 1'b1;
      feed_small(8'h01, 32'h87654321, 8);
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", s_hash_valid); end
      checks++; if (s_hash !== 4'h1) begin errors++; $display("FAIL basic_hash got %h exp 1", s_hash); end
`ifdef TOEPLITZ_PARITY_EN
      checks++; if (s_par !== 1'b1) begin errors++; $display("FAIL basic_par got %b exp 1", s_par); end
`endif
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", s_hash_valid); end
      checks++; if (s_data_ready !== 1'b1) begin errors++; $display("FAIL basic_data_ready got %b exp 1", s_data_ready); end
   endtask

   task automatic test_patterns;
      s_hash_ready = 1'b1;
      feed_small(8'hFF, 32'hAAAAAAAA, 8);
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b1 || s_hash !== 4'h0) begin errors++; $display("FAIL even_hash got %b/%h exp 1/0", s_hash_valid, s_hash); end
`ifdef TOEPLITZ_PARITY_EN
      checks++; if (s_par !== 1'b0) begin errors++; $display("FAIL even_par got %b exp 0", s_par); end
`endif
      @(negedge clk);
      feed_small(8'h01, 32'hFFFFFFF7, 8);
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b1 || s_hash !== 4'h7) begin errors++; $display("FAIL col0_hash got %b/%h exp 1/7", s_hash_valid, s_hash); end
`ifdef TOEPLITZ_PARITY_EN
      checks++; if (s_par !== 1'b1) begin errors++; $display("FAIL col0_par got %b exp 1", s_par); end
`endif
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      s_hash_ready = 1'b0;
      feed_small(8'h21, 32'h00C00003, 8);
      s_data_valid = 1'b1;
      s_col_valid  = 1'b1;
      s_data_in    = 4'hF;
      s_col        = 4'hF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (s_hash_valid !== 1'b1 || s_hash !== 4'hF || s_col_ready !== 1'b0 || s_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d got v=%b h=%h cr=%b dr=%b exp v=1 h=f cr=0 dr=0",
                     i, s_hash_valid, s_hash, s_col_ready, s_data_ready);
         end
      end
      s_data_valid = 1'b0;
      s_col_valid  = 1'b0;
      s_hash_ready = 1'b1;
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", s_hash_valid); end
      feed_small(8'h80, 32'h5AAAAAAA, 8);
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b1 || s_hash !== 4'h5) begin errors++; $display("FAIL stall_next_block got %b/%h exp 1/5", s_hash_valid, s_hash); end
      @(negedge clk);
   endtask

   task automatic test_mid_reset;
      s_hash_ready = 1'b1;
      feed_small(8'hFF, 32'h00098421, 5);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (s_col_ready !== 1'b0 || s_data_ready !== 1'b1 || s_hash_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state got cr=%b dr=%b v=%b exp 0/1/0", s_col_ready, s_data_ready, s_hash_valid);
      end
      rst_n = 1'b1;
      feed_small(8'h03, 32'hEEEEEE21, 8);
      @(negedge clk);
      checks++; if (s_hash_valid !== 1'b1 || s_hash !== 4'h3) begin errors++; $display("FAIL midrst_hash got %b/%h exp 1/3", s_hash_valid, s_hash); end
      @(negedge clk);
   endtask

   task automatic test_random_blocks;
      logic [255:0] blk;
      logic [127:0] cols [256];
      logic [127:0] exp_h;
      int  wi, ci, guard;
      bit  df, cf;
      d_hash_ready = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int j = 0; j < 8; j++) blk[j*32 +: 32] = $urandom;
         exp_h = '0;
         for (int k = 0; k < 256; k++) begin
            cols[k] = {$urandom, $urandom, $urandom, $urandom};
            if (blk[k]) exp_h = exp_h ^ cols[k];
         end
         wi = 0; ci = 0; guard = 0;
         while (ci < 256 && guard < 4000) begin
            @(negedge clk);
            d_data_valid = (wi < 4) && ($urandom_range(0, 1) == 1);
            d_data_in    = blk[(wi % 4)*64 +: 64];
            d_col_valid  = ($urandom_range(0, 1) == 1);
            d_col        = cols[ci];
            df = d_data_ready && d_data_valid;
            cf = d_col_ready && d_col_valid;
            @(posedge clk);
            if (df) wi++;
            if (cf) ci++;
            guard++;
         end
         #1;
         d_data_valid = 1'b0;
         d_col_valid  = 1'b0;
         @(negedge clk);
         checks++;
         if (d_hash_valid !== 1'b1 || d_hash !== exp_h) begin
            errors++;
            $display("FAIL random_block%0d got v=%b h=%h exp v=1 h=%h", b, d_hash_valid, d_hash, exp_h);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n        = 1'b0;
      s_col        = '0; s_col_valid  = 1'b0;
      s_data_in    = '0; s_data_valid = 1'b0;
      s_hash_ready = 1'b1;
      d_col        = '0; d_col_valid  = 1'b0;
      d_data_in    = '0; d_data_valid = 1'b0;
      d_hash_ready = 1'b1;

      test_reset;
      test_timing;
      test_basic;
      test_patterns;
      test_backpressure;
      test_mid_reset;
      test_random_blocks;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
